// File: rtl/refill_controller.sv
// ---------------------------------------------------------------------------
// refill_controller
//
// Fetches one instruction-cache line after a miss. The controller:
//   - accepts a miss and aligns its address to the start of the line,
//   - issues a single line request to external memory,
//   - forwards LINE_BEATS 80-bit packets from the memory buffer into the
//     cache write port,
//   - reports completion (o_refill_done) or a stalled memory (o_refill_err).
//
// Ports
//   clk              : clock; all state changes on the rising edge
//   arst_n           : synchronous active-low reset
//   i_flush          : abandon any refill and return to IDLE
//   i_miss_valid     : cache miss request valid
//   i_miss_addr      : address of the missing word
//   o_miss_ready     : controller can accept a miss (IDLE only)
//   o_mem_req_valid  : line request to memory valid
//   o_mem_req_addr   : line-aligned request address
//   i_mem_req_ready  : memory accepted the line request
//   i_buf_data       : packet from the memory buffer
//   i_buf_valid      : packet valid
//   o_buf_halt       : asks the buffer to hold its current packet
//   o_fill_valid     : cache write strobe
//   o_fill_addr      : word address being written
//   o_fill_data      : word data being written
//   o_fill_last      : current beat is the final beat of the line
//   i_fill_ready     : cache can accept a write
//   o_refill_done    : one-cycle pulse, line fully written
//   o_refill_err     : one-cycle pulse, memory went silent too long
// ---------------------------------------------------------------------------
module refill_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_BEATS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_flush,
    input  logic                  i_miss_valid,
    input  logic [ADDR_WIDTH-1:0] i_miss_addr,
    output logic                  o_miss_ready,
    output logic                  o_mem_req_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_req_ready,
    input  logic [79:0]           i_buf_data,
    input  logic                  i_buf_valid,
    output logic                  o_buf_halt,
    output logic                  o_fill_valid,
    output logic [ADDR_WIDTH-1:0] o_fill_addr,
    output logic [79:0]           o_fill_data,
    output logic                  o_fill_last,
    input  logic                  i_fill_ready,
    output logic                  o_refill_done,
    output logic                  o_refill_err
);

    localparam int BW = $clog2(LINE_BEATS);
    localparam logic [BW-1:0]         LAST_BEAT = BW'(LINE_BEATS - 1);
    localparam logic [9:0]            TMO_LAST  = 10'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q,  base_d;
    logic [BW-1:0]         beat_q,  beat_d;
    logic [9:0]            timer_q, timer_d;
    logic                  accept;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            timer_q <= timer_d;
        end
    end

    // A flush suppresses the write in the same cycle it is raised.
    assign accept = (state_q == WAIT) && i_buf_valid && i_fill_ready && !i_flush;

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        beat_d          = beat_q;
        timer_d         = timer_q;
        o_miss_ready    = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_req_addr  = '0;
        o_buf_halt      = 1'b0;
        o_fill_valid    = 1'b0;
        o_fill_addr     = '0;
        o_fill_data     = '0;
        o_fill_last     = 1'b0;
        o_refill_done   = 1'b0;
        o_refill_err    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Not ready while flushing: the flush keeps us in IDLE, so a
                // handshake completed now would be lost.
                o_miss_ready = !i_flush;
                if (i_miss_valid) begin
                    base_d  = i_miss_addr & LINE_MASK;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_mem_req_valid = !i_flush;
                o_mem_req_addr  = base_q;
                if (i_mem_req_ready) begin
                    beat_d  = '0;
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                o_buf_halt   = !i_fill_ready;
                o_fill_valid = accept;
                o_fill_data  = i_buf_data;
                o_fill_addr  = base_q | ADDR_WIDTH'(beat_q);
                o_fill_last  = (beat_q == LAST_BEAT);
                if (accept) begin
                    timer_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end else if (i_fill_ready) begin
                    // Only memory silence counts toward the timeout; a cache
                    // stall (i_fill_ready low) freezes the timer.
                    if (timer_q >= TMO_LAST) begin
                        state_d = ERR;
                    end else begin
                        timer_d = timer_q + 10'd1;
                    end
                end
            end
            DONE: begin
                o_refill_done = !i_flush;
                state_d       = IDLE;
            end
            ERR: begin
                o_refill_err = !i_flush;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_flush) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_refill_controller.sv
module tb_refill_controller;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_flush;
    logic        i_miss_valid;
    logic [15:0] i_miss_addr;
    logic        o_miss_ready;
    logic        o_mem_req_valid;
    logic [15:0] o_mem_req_addr;
    logic        i_mem_req_ready;
    logic [79:0] i_buf_data;
    logic        i_buf_valid;
    logic        o_buf_halt;
    logic        o_fill_valid;
    logic [15:0] o_fill_addr;
    logic [79:0] o_fill_data;
    logic        o_fill_last;
    logic        i_fill_ready;
    logic        o_refill_done;
    logic        o_refill_err;

    always #5 clk = ~clk;

    refill_controller #(.ADDR_WIDTH(16), .LINE_BEATS(4), .TIMEOUT(8)) dut (
        .clk(clk), .arst_n(arst_n), .i_flush(i_flush),
        .i_miss_valid(i_miss_valid), .i_miss_addr(i_miss_addr), .o_miss_ready(o_miss_ready),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
        .i_mem_req_ready(i_mem_req_ready),
        .i_buf_data(i_buf_data), .i_buf_valid(i_buf_valid), .o_buf_halt(o_buf_halt),
        .o_fill_valid(o_fill_valid), .o_fill_addr(o_fill_addr), .o_fill_data(o_fill_data),
        .o_fill_last(o_fill_last), .i_fill_ready(i_fill_ready),
        .o_refill_done(o_refill_done), .o_refill_err(o_refill_err)
    );

    typedef struct {
        logic         rst_n;
        logic         flush;
        logic         mv;
        logic [15:0]  ma;
        logic         mr;
        logic         bv;
        logic [79:0]  bd;
        logic         fr;
        logic [118:0] exp;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    vec_t tbl[$];

    // Expected output bundle: {miss_ready, req_valid, req_addr, fill_valid,
    // fill_addr, fill_data, fill_last, halt, done, err}
    function automatic logic [118:0] E(logic mrdy, logic rqv, logic [15:0] rqa, logic fv,
                                       logic [15:0] fa, logic [79:0] fd, logic fl,
                                       logic halt, logic done, logic err);
        return {mrdy, rqv, rqa, fv, fa, fd, fl, halt, done, err};
    endfunction

    function automatic logic [118:0] outs();
        return {o_miss_ready, o_mem_req_valid, o_mem_req_addr, o_fill_valid, o_fill_addr,
                o_fill_data, o_fill_last, o_buf_halt, o_refill_done, o_refill_err};
    endfunction

    function automatic logic [79:0] D(int n);
        return 80'h0123_4567_89AB_CDEF_0000 | 80'(n);
    endfunction

    function automatic vec_t V(logic flush, logic mv, logic [15:0] ma, logic mr, logic bv,
                               logic [79:0] bd, logic fr, logic [118:0] e);
        vec_t v;
        v.rst_n = 1'b1; v.flush = flush; v.mv = mv; v.ma = ma; v.mr = mr;
        v.bv = bv; v.bd = bd; v.fr = fr; v.exp = e;
        return v;
    endfunction

    // Common expectations
    function automatic logic [118:0] EI();                      return E(1,0,0,0,0,0,0,0,0,0); endfunction
    function automatic logic [118:0] EQ(logic [15:0] a);        return E(0,1,a,0,0,0,0,0,0,0); endfunction
    function automatic logic [118:0] EW(logic [15:0] a, logic [79:0] d, logic l);
        return E(0,0,0,1,a,d,l,0,0,0);
    endfunction
    function automatic logic [118:0] ED();                      return E(0,0,0,0,0,0,0,0,1,0); endfunction

    task automatic chk(string nm, logic [118:0] act, logic [118:0] want);
        n_tot++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, want);
    endtask

    task automatic drive(vec_t v);
        arst_n = v.rst_n; i_flush = v.flush; i_miss_valid = v.mv; i_miss_addr = v.ma;
        i_mem_req_ready = v.mr; i_buf_valid = v.bv; i_buf_data = v.bd; i_fill_ready = v.fr;
    endtask

    task automatic step(vec_t v, string nm);
        drive(v);
        @(negedge clk);
        chk(nm, outs(), v.exp);
        @(posedge clk);
        #1;
    endtask

    // One full line (4 beats + done + idle) starting from REQ at base b
    task automatic full_line(logic [15:0] b, string nm);
        step(V(0,0,0,1,0,0,1,EQ(b)), {nm, "_req"});
        for (int k = 0; k < 4; k++)
            step(V(0,0,0,0,1,D(k),1,EW(b | 16'(k), D(k), k == 3)), {nm, "_beat"});
        step(V(0,0,0,0,0,0,1,ED()), {nm, "_done"});
        step(V(0,0,0,0,0,0,1,EI()), {nm, "_idle"});
    endtask

    initial begin
        int err_at, err_cnt, halt_cnt, done_cnt;
        logic mr_after;

        drive(V(0,0,0,0,0,0,1,EI()));
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // --- nominal line: miss 0x13 -> base 0x10
        tbl.push_back(V(0,0,16'h0000,0,0,0,1,EI()));
        tbl.push_back(V(0,1,16'h0013,0,0,0,1,EI()));
        tbl.push_back(V(0,0,0,1,0,0,1,EQ(16'h0010)));
        tbl.push_back(V(0,0,0,0,1,D(0),1,EW(16'h0010,D(0),0)));
        tbl.push_back(V(0,0,0,0,1,D(1),1,EW(16'h0011,D(1),0)));
        tbl.push_back(V(0,0,0,0,1,D(2),1,EW(16'h0012,D(2),0)));
        tbl.push_back(V(0,0,0,0,1,D(3),1,EW(16'h0013,D(3),1)));
        tbl.push_back(V(0,0,0,0,0,0,1,ED()));
        tbl.push_back(V(0,0,0,0,0,0,1,EI()));
        // --- backpressure on beat 1: miss 0x26 -> base 0x24
        tbl.push_back(V(0,1,16'h0026,0,0,0,1,EI()));
        tbl.push_back(V(0,0,0,1,0,0,1,EQ(16'h0024)));
        tbl.push_back(V(0,0,0,0,1,D(4),1,EW(16'h0024,D(4),0)));
        for (int k = 0; k < 3; k++)
            tbl.push_back(V(0,0,0,0,1,D(5),0,E(0,0,0,0,16'h0025,D(5),0,1,0,0)));
        tbl.push_back(V(0,0,0,0,1,D(5),1,EW(16'h0025,D(5),0)));
        tbl.push_back(V(0,0,0,0,1,D(6),1,EW(16'h0026,D(6),0)));
        tbl.push_back(V(0,0,0,0,1,D(7),1,EW(16'h0027,D(7),1)));
        tbl.push_back(V(0,0,0,0,0,0,1,ED()));
        tbl.push_back(V(0,0,0,0,0,0,1,EI()));
        // --- flush after two beats, then a new miss completes normally
        tbl.push_back(V(0,1,16'h0040,0,0,0,1,EI()));
        tbl.push_back(V(0,0,0,1,0,0,1,EQ(16'h0040)));
        tbl.push_back(V(0,0,0,0,1,D(8),1,EW(16'h0040,D(8),0)));
        tbl.push_back(V(0,0,0,0,1,D(9),1,EW(16'h0041,D(9),0)));
        tbl.push_back(V(1,0,0,0,1,D(10),1,E(0,0,0,0,16'h0042,D(10),0,0,0,0)));
        tbl.push_back(V(0,0,0,0,1,D(11),1,EI()));
        tbl.push_back(V(0,1,16'h0051,0,0,0,1,EI()));
        tbl.push_back(V(0,0,0,1,0,0,1,EQ(16'h0050)));
        for (int k = 0; k < 4; k++)
            tbl.push_back(V(0,0,0,0,1,D(20+k),1,EW(16'h0050 | 16'(k),D(20+k),k == 3)));
        tbl.push_back(V(0,0,0,0,0,0,1,ED()));
        tbl.push_back(V(0,0,0,0,0,0,1,EI()));
        // --- memory request accepted only after 5 cycles; buf_valid in REQ ignored
        tbl.push_back(V(0,1,16'h0088,0,0,0,1,EI()));
        for (int k = 0; k < 5; k++)
            tbl.push_back(V(0,0,0,0,k[0],D(30),1,EQ(16'h0088)));
        tbl.push_back(V(0,0,0,1,0,0,1,EQ(16'h0088)));
        tbl.push_back(V(0,0,0,0,0,0,1,E(0,0,0,0,16'h0088,0,0,0,0,0)));
        for (int k = 0; k < 4; k++)
            tbl.push_back(V(0,0,0,0,1,D(40+k),1,EW(16'h0088 | 16'(k),D(40+k),k == 3)));
        tbl.push_back(V(0,0,0,0,0,0,1,ED()));
        tbl.push_back(V(0,0,0,0,0,0,1,EI()));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // --- timeout: no data after the request is accepted
        step(V(0,1,16'h0100,0,0,0,1,EI()), "tmo_miss");
        step(V(0,0,0,1,0,0,1,EQ(16'h0100)), "tmo_req");
        drive(V(0,0,0,0,0,0,1,EI()));
        err_at = -1; err_cnt = 0; mr_after = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (err_at >= 0 && i == err_at + 1) mr_after = o_miss_ready;
            if (o_refill_err) begin
                if (err_at < 0) err_at = i;
                err_cnt++;
            end
            @(posedge clk);
            #1;
        end
        chk("tmo_cycle", 119'(err_at), 119'(8));
        chk("tmo_pulses", 119'(err_cnt), 119'(1));
        chk("tmo_ready_after", 119'(mr_after), 119'(1));

        // --- downstream stall must not advance the timer; beats clear it
        step(V(0,1,16'h0202,0,0,0,1,EI()), "hold_miss");
        step(V(0,0,0,1,0,0,1,EQ(16'h0200)), "hold_req");
        err_cnt = 0; halt_cnt = 0; done_cnt = 0;
        drive(V(0,0,0,0,1,D(50),0,EI()));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_buf_halt) halt_cnt++;
            if (o_refill_err) err_cnt++;
            @(posedge clk);
            #1;
        end
        for (int b = 0; b < 4; b++) begin
            drive(V(0,0,0,0,0,0,1,EI()));
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                if (o_refill_err) err_cnt++;
                @(posedge clk);
                #1;
            end
            step(V(0,0,0,0,1,D(60+b),1,EW(16'h0200 | 16'(b),D(60+b),b == 3)), "hold_beat");
        end
        drive(V(0,0,0,0,0,0,1,EI()));
        @(negedge clk);
        if (o_refill_done) done_cnt++;
        @(posedge clk);
        #1;
        chk("hold_halt_cycles", 119'(halt_cnt), 119'(20));
        chk("hold_no_err", 119'(err_cnt), 119'(0));
        chk("hold_done", 119'(done_cnt), 119'(1));

        // --- reset in WAIT at beat 1, then a full refill
        step(V(0,1,16'h0301,0,0,0,1,EI()), "rst_miss");
        step(V(0,0,0,1,0,0,1,EQ(16'h0300)), "rst_req");
        step(V(0,0,0,0,1,D(70),1,EW(16'h0300,D(70),0)), "rst_beat0");
        drive(V(0,0,0,0,1,D(71),1,EI()));
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        step(V(0,0,0,0,1,D(72),1,EI()), "rst_after");
        step(V(0,1,16'h0305,0,0,0,1,EI()), "rst_new_miss");
        full_line(16'h0304, "rst_line");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/refill_controller.md
REFILL_CONTROLLER -- requirements
Module: refill_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: instruction line/word address width.
REQ-002 SHALL have parameter LINE_BEATS, default 4: number of 80-bit beats per cache line; a power of 2, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum idle cycles in WAIT before an error; range 1..1023.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge only.
REQ-005 SHALL have port arst_n, input, 1 bit: reset, synchronous, active-low (despite the name, sampled on posedge clk only).
REQ-006 SHALL have port i_flush, input, 1 bit: abort any refill in progress.
REQ-007 SHALL have ports i_miss_valid (input, 1), i_miss_addr (input, ADDR_WIDTH) and o_miss_ready (output, 1): miss request handshake from the cache.
REQ-008 SHALL have ports o_mem_req_valid (output, 1), o_mem_req_addr (output, ADDR_WIDTH) and i_mem_req_ready (input, 1): external memory line request.
REQ-009 SHALL have ports i_buf_data (input, 80) and i_buf_valid (input, 1): assembled packet from the memory buffer.
REQ-010 SHALL have port o_buf_halt, output, 1 bit: drives the memory buffer halt input.
REQ-011 SHALL have ports o_fill_valid (output, 1), o_fill_addr (output, ADDR_WIDTH), o_fill_data (output, 80), o_fill_last (output, 1) and i_fill_ready (input, 1): cache line write port.
REQ-012 SHALL have ports o_refill_done (output, 1) and o_refill_err (output, 1): one-cycle status pulses.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, DONE, ERR.
REQ-014 IDLE: o_miss_ready=1; on i_miss_valid, SHALL latch base = i_miss_addr with the low log2(LINE_BEATS) bits cleared, then go to REQ.
REQ-015 REQ: o_mem_req_valid=1 and o_mem_req_addr=base, held stable; on i_mem_req_ready, SHALL go to WAIT with beat=0 and timer=0.
REQ-016 WAIT: a beat SHALL be accepted in any cycle where i_buf_valid=1 and i_fill_ready=1.
REQ-017 In WAIT, the following SHALL be combinational: o_fill_valid = i_buf_valid & i_fill_ready; o_fill_data = i_buf_data; o_fill_addr = base | beat; o_fill_last = (beat == LINE_BEATS-1).
REQ-018 o_buf_halt SHALL be ~i_fill_ready while in WAIT, and 0 in all other states; the buffer therefore holds the packet until it is accepted.
REQ-019 Each accepted beat SHALL increment beat and clear timer; the last accepted beat SHALL move to DONE.
REQ-020 In WAIT with no accepted beat, timer SHALL increment; when timer reaches TIMEOUT, SHALL go to ERR (so ERR is entered TIMEOUT cycles after the last progress).
REQ-021 While i_fill_ready=0, the timer SHALL NOT increment (the stall is downstream, not memory).
REQ-022 DONE SHALL assert o_refill_done=1 for exactly one cycle, then go to IDLE.
REQ-023 ERR SHALL assert o_refill_err=1 for exactly one cycle, then go to IDLE; no retry is issued.
REQ-024 o_miss_ready SHALL be 0 in all states other than IDLE; a miss arriving in DONE or ERR waits for IDLE.
REQ-025 i_flush=1 in any state SHALL force IDLE next cycle, take priority over every other transition, produce no done or err pulse, and block o_fill_valid in the same cycle.
REQ-026 Outside WAIT, o_fill_valid, o_fill_last and o_buf_halt SHALL be 0; i_buf_valid outside WAIT SHALL be ignored.
REQ-027 beat SHALL be log2(LINE_BEATS) bits wide and timer 10 bits wide, with no wrap; the FSM exits WAIT before either counter overflows.

Reset
REQ-028 arst_n=0 at posedge SHALL force IDLE and clear base, beat and timer.
REQ-029 After reset, all outputs SHALL be 0 except o_miss_ready=1.
REQ-030 Reset mid-refill SHALL abandon the line with no done or err pulse.

Verification
REQ-031 Nominal: miss addr 0x0013, req ready immediately, 4 consecutive valid beats -> o_mem_req_addr=0x0010; fill addrs 0x10..0x13; o_fill_last only on 0x13; o_refill_done one cycle after the last beat.
REQ-032 Backpressure: i_fill_ready=0 for 3 cycles on beat 1 -> o_buf_halt=1 for those 3 cycles; no fill; timer holds; beat 1 written when ready returns.
REQ-033 Timeout with TIMEOUT=8: request accepted, no i_buf_valid -> o_refill_err pulses exactly 8 cycles after entering WAIT; o_miss_ready=1 the following cycle.
REQ-034 Flush after beat 2 -> no further fills, no done pulse, IDLE next cycle; a new miss is then accepted normally.
REQ-035 Delayed i_mem_req_ready (5 cycles) -> o_mem_req_valid and addr stable throughout; i_buf_valid pulsed during REQ produces no fill.
REQ-036 arst_n low in WAIT at beat 1 -> next cycle all outputs at reset values; a subsequent miss completes a full 4-beat refill.
